imgproc_msg_reader: RTL

//  Avalon-MM master that drains the image processor's message FIFO without CPU help.
//  It checks the processor ID, then polls the status register for the FIFO word count.
//  It reads messages three words at a time, decodes "RBB" bounding-box messages and presents them to rover control.

---
 rtl/imgproc_msg_pkg.sv | 40 ++++
 rtl/imgproc_msg_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imgproc_msg_pkg.sv
// Shared constants and types for the image processor message interface.
package imgproc_msg_pkg;

  // Slave register map
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_MSG    = 3'd1;
  localparam logic [2:0] ADDR_ID     = 3'd2;
  localparam logic [2:0] ADDR_BBCOL  = 3'd3;

  // "RBB" bounding-box message header
  localparam logic [31:0] MSG_ID = 32'h00524242;

  // Status register layout
  localparam int unsigned STAT_FLUSH_BIT = 4;
  localparam int unsigned STAT_CNT_MSB   = 15;
  localparam int unsigned STAT_CNT_LSB   = 8;
  localparam logic [31:0] STAT_FLUSH_CMD = 32'd1 << STAT_FLUSH_BIT;

  localparam int unsigned COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [3:0] {
    StCheckId,
    StWaitId,
    StFault,
    StIdle,
    StFlush,
    StRdStat,
    StWaitStat,
    StRdMsg,
    StWaitMsg
  } state_e;

  // A box is non-empty when its corners are ordered on both axes.
  function automatic logic box_nonempty(coord_t x_min, coord_t y_min, coord_t x_max,
                                        coord_t y_max);
    return (x_min <= x_max) && (y_min <= y_max);
  endfunction

endpackage

// File: rtl/imgproc_msg_reader.sv
// Avalon-MM master that drains the image processor message FIFO and decodes
// "RBB" bounding-box messages for rover control.
module imgproc_msg_reader
  import imgproc_msg_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter logic [31:0] EXPECTED_ID   = 32'h1234EEE2,
  parameter logic [31:0] MSG_ID        = imgproc_msg_pkg::MSG_ID,
  parameter int unsigned IMAGE_W       = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        flush_req,
  output logic        bb_valid,
  output logic        bb_found,
  output logic [10:0] bb_left,
  output logic [10:0] bb_top,
  output logic [10:0] bb_right,
  output logic [10:0] bb_bottom,
  output logic        id_error,
  output logic [7:0]  sync_err_cnt
);

  localparam logic [31:0] PollLast = 32'(POLL_INTERVAL - 1);

  state_e      state_q, state_d;
  logic [31:0] poll_cnt_q, poll_cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  remaining_q, remaining_d;
  coord_t      x_min_q, x_min_d, y_min_q, y_min_d;

  logic        m_read_q, m_read_d;
  logic        m_write_q, m_write_d;
  logic [2:0]  m_address_q, m_address_d;
  logic [31:0] m_writedata_q, m_writedata_d;
  logic        bb_valid_q, bb_valid_d;
  logic        bb_found_q, bb_found_d;
  coord_t      bb_left_q, bb_left_d, bb_top_q, bb_top_d;
  coord_t      bb_right_q, bb_right_d, bb_bottom_q, bb_bottom_d;
  logic        id_error_q, id_error_d;
  logic [7:0]  sync_err_cnt_q, sync_err_cnt_d;

  logic [7:0]  stat_cnt;
  logic [7:0]  rem_dec;
  coord_t      w_hi, w_lo;

  assign stat_cnt = m_readdata[STAT_CNT_MSB:STAT_CNT_LSB];
  assign rem_dec  = remaining_q - 8'd1;
  assign w_hi     = m_readdata[26:16];
  assign w_lo     = m_readdata[10:0];

  // Next-state, message decode and registered bus strobe generation
  always_comb begin
    state_d        = state_q;
    poll_cnt_d     = poll_cnt_q;
    flush_pend_d   = flush_pend_q;
    idx_d          = idx_q;
    remaining_d    = remaining_q;
    x_min_d        = x_min_q;
    y_min_d        = y_min_q;
    bb_valid_d     = 1'b0;
    bb_found_d     = bb_found_q;
    bb_left_d      = bb_left_q;
    bb_top_d       = bb_top_q;
    bb_right_d     = bb_right_q;
    bb_bottom_d    = bb_bottom_q;
    id_error_d     = id_error_q;
    sync_err_cnt_d = sync_err_cnt_q;

    case (state_q)
      // The ID read strobe is raised on the first cycle here, then we move on.
      StCheckId: begin
        if (m_read_q) state_d = StWaitId;
      end
      StWaitId: begin
        if (m_readdata == EXPECTED_ID) begin
          state_d = StIdle;
        end else begin
          state_d    = StFault;
          id_error_d = 1'b1;
        end
      end
      StFault: state_d = StFault;
      StIdle: begin
        if (poll_cnt_q == PollLast) begin
          poll_cnt_d = '0;
          state_d    = flush_pend_q ? StFlush : StRdStat;
        end else begin
          poll_cnt_d = poll_cnt_q + 32'd1;
        end
      end
      StFlush: begin
        flush_pend_d = 1'b0;
        idx_d        = '0;
        state_d      = StIdle;
      end
      StRdStat: state_d = StWaitStat;
      StWaitStat: begin
        if (stat_cnt >= 8'd3) begin
          remaining_d = stat_cnt;
          state_d     = StRdMsg;
        end else begin
          state_d = StIdle;
        end
      end
      StRdMsg: state_d = StWaitMsg;
      StWaitMsg: begin
        remaining_d = rem_dec;
        case (idx_q)
          2'd0: begin
            if (m_readdata == MSG_ID) begin
              idx_d = 2'd1;
            end else if (sync_err_cnt_q != 8'hFF) begin
              sync_err_cnt_d = sync_err_cnt_q + 8'd1;
            end
          end
          2'd1: begin
            x_min_d = w_hi;
            y_min_d = w_lo;
            idx_d   = 2'd2;
          end
          2'd2: begin
            bb_left_d   = x_min_q;
            bb_top_d    = y_min_q;
            bb_right_d  = w_hi;
            bb_bottom_d = w_lo;
            // A right edge beyond the frame means a corrupt box, never a found one.
            bb_found_d  = box_nonempty(x_min_q, y_min_q, w_hi, w_lo) &&
                          (32'(w_hi) < IMAGE_W);
            bb_valid_d  = 1'b1;
            idx_d       = 2'd0;
          end
          default: idx_d = 2'd0;
        endcase
        // Only start a new message when all three of its words are already queued.
        if ((rem_dec >= 8'd1) && ((idx_d != 2'd0) || (rem_dec >= 8'd3))) begin
          state_d = StRdMsg;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StFault;
    endcase

    // A request arriving while FLUSH clears the flag still wins.
    if (flush_req) flush_pend_d = 1'b1;

    // Strobes are registered: they are high for exactly the cycle spent in an issue state.
    m_read_d      = (state_d == StCheckId) || (state_d == StRdStat) || (state_d == StRdMsg);
    m_write_d     = (state_d == StFlush);
    m_writedata_d = m_write_d ? STAT_FLUSH_CMD : '0;
    case (state_d)
      StCheckId:         m_address_d = ADDR_ID;
      StRdStat, StFlush: m_address_d = ADDR_STATUS;
      StRdMsg:           m_address_d = ADDR_MSG;
      default:           m_address_d = m_address_q;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StCheckId;
      poll_cnt_q     <= '0;
      flush_pend_q   <= 1'b0;
      idx_q          <= '0;
      remaining_q    <= '0;
      x_min_q        <= '0;
      y_min_q        <= '0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_address_q    <= '0;
      m_writedata_q  <= '0;
      bb_valid_q     <= 1'b0;
      bb_found_q     <= 1'b0;
      bb_left_q      <= '0;
      bb_top_q       <= '0;
      bb_right_q     <= '0;
      bb_bottom_q    <= '0;
      id_error_q     <= 1'b0;
      sync_err_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      poll_cnt_q     <= poll_cnt_d;
      flush_pend_q   <= flush_pend_d;
      idx_q          <= idx_d;
      remaining_q    <= remaining_d;
      x_min_q        <= x_min_d;
      y_min_q        <= y_min_d;
      m_read_q       <= m_read_d;
      m_write_q      <= m_write_d;
      m_address_q    <= m_address_d;
      m_writedata_q  <= m_writedata_d;
      bb_valid_q     <= bb_valid_d;
      bb_found_q     <= bb_found_d;
      bb_left_q      <= bb_left_d;
      bb_top_q       <= bb_top_d;
      bb_right_q     <= bb_right_d;
      bb_bottom_q    <= bb_bottom_d;
      id_error_q     <= id_error_d;
      sync_err_cnt_q <= sync_err_cnt_d;
    end
  end

  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_chipselect = m_read_q | m_write_q;
  assign m_address    = m_address_q;
  assign m_writedata  = m_writedata_q;
  assign bb_valid     = bb_valid_q;
  assign bb_found     = bb_found_q;
  assign bb_left      = bb_left_q;
  assign bb_top       = bb_top_q;
  assign bb_right     = bb_right_q;
  assign bb_bottom    = bb_bottom_q;
  assign id_error     = id_error_q;
  assign sync_err_cnt = sync_err_cnt_q;

endmodule
